// File: rtl/csr_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : csr_unit_if
// Description : Execute-stage bundle between the core and csr_unit: Zicsr
//               access, trap/mret events, retire strobe and the PC redirect.
//               master = core side, slave = csr_unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface csr_unit_if #(
    parameter int XLEN = 64
);
    logic            csr_valid;
    logic [1:0]      csr_op;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_wdata;
    logic [XLEN-1:0] csr_rdata;
    logic            csr_illegal;
    logic            trap_valid;
    logic [XLEN-1:0] trap_cause;
    logic [XLEN-1:0] trap_pc;
    logic            mret;
    logic            instret;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        output csr_valid, csr_op, csr_addr, csr_wdata,
        output trap_valid, trap_cause, trap_pc, mret, instret,
        input  csr_rdata, csr_illegal, redirect_valid, redirect_pc
    );

    modport slave (
        input  csr_valid, csr_op, csr_addr, csr_wdata,
        input  trap_valid, trap_cause, trap_pc, mret, instret,
        output csr_rdata, csr_illegal, redirect_valid, redirect_pc
    );
endinterface
`default_nettype wire

// File: rtl/csr_unit.sv
`default_nettype none
// ============================================================================
// Module      : csr_unit
// Description : Machine-mode CSR unit. Zicsr RW/RS/RC on mstatus, mtvec,
//               mscratch, mepc, mcause, mhartid; trap entry and mret with
//               mstatus MIE/MPIE stacking; registered one-cycle PC redirect.
//               Optional macro CSR_COUNTERS_EN adds mcycle/minstret (64-bit),
//               their read-only user aliases and, for XLEN=32, the upper
//               halves mcycleh/minstreth.
// Ports       : clk, rst (synchronous, active-high)
//               bus (csr_unit_if.slave): csr_valid/op/addr/wdata in,
//               csr_rdata/csr_illegal out (combinational), trap_valid/
//               trap_cause/trap_pc/mret/instret in, redirect_valid/
//               redirect_pc out.
// Revision    : 1.0 - initial release
// ============================================================================
module csr_unit #(
    parameter int          XLEN        = 64,
    parameter logic [63:0] MSTATUS_RST = 64'h0000_000a_0000_1800
) (
    input  wire logic    clk,
    input  wire logic    rst,
    csr_unit_if.slave    bus
);
    localparam logic [11:0] c_A_MSTATUS  = 12'h300;
    localparam logic [11:0] c_A_MTVEC    = 12'h305;
    localparam logic [11:0] c_A_MSCRATCH = 12'h340;
    localparam logic [11:0] c_A_MEPC     = 12'h341;
    localparam logic [11:0] c_A_MCAUSE   = 12'h342;
    localparam logic [11:0] c_A_MHARTID  = 12'hF14;

    // mstatus image with the writable MIE/MPIE bits cleared and MPP pinned to M.
    localparam logic [63:0]     c_MST_FIXED64 = (MSTATUS_RST & ~64'h88) | 64'h1800;
    localparam logic [XLEN-1:0] c_MST_FIXED   = c_MST_FIXED64[XLEN-1:0];

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_REDIR = 1'b1;

    logic            r_mie, r_mpie;
    logic [XLEN-1:0] r_mtvec, r_mscratch, r_mepc, r_mcause;
    logic [XLEN-1:0] r_redirect_pc;
    logic [0:0]      r_state, w_state_nxt;

    logic [XLEN-1:0] w_mstatus;
    logic [XLEN-1:0] w_rd;
    logic [XLEN-1:0] w_new;
    logic            w_impl;
    logic            w_ro;
    logic            w_wr_try;
    logic            w_wen;
    logic            w_event;

`ifdef CSR_COUNTERS_EN
    logic [63:0] r_mcycle, r_minstret;
    logic [63:0] w_cyc_hi, w_ret_hi, w_wr64;
`endif

    // ------------------------------------------------------------------
    // Read mux and write-value computation
    // ------------------------------------------------------------------
    always_comb begin
        w_mstatus    = c_MST_FIXED;
        w_mstatus[3] = r_mie;
        w_mstatus[7] = r_mpie;
    end

`ifdef CSR_COUNTERS_EN
    assign w_cyc_hi = {32'h0, r_mcycle[63:32]};
    assign w_ret_hi = {32'h0, r_minstret[63:32]};
`endif

    always_comb begin
        w_impl = 1'b1;
        w_rd   = '0;
        case (bus.csr_addr)
            c_A_MSTATUS:  w_rd = w_mstatus;
            c_A_MTVEC:    w_rd = r_mtvec;
            c_A_MSCRATCH: w_rd = r_mscratch;
            c_A_MEPC:     w_rd = r_mepc;
            c_A_MCAUSE:   w_rd = r_mcause;
            c_A_MHARTID:  w_rd = '0;
`ifdef CSR_COUNTERS_EN
            12'hB00, 12'hC00: w_rd = r_mcycle[XLEN-1:0];
            12'hB02, 12'hC02: w_rd = r_minstret[XLEN-1:0];
            12'hB80: begin
                if (XLEN == 32) w_rd = w_cyc_hi[XLEN-1:0];
                else            w_impl = 1'b0;
            end
            12'hB82: begin
                if (XLEN == 32) w_rd = w_ret_hi[XLEN-1:0];
                else            w_impl = 1'b0;
            end
`endif
            default: w_impl = 1'b0;
        endcase
    end

    always_comb begin
        case (bus.csr_op)
            2'b01:   w_new = bus.csr_wdata;
            2'b10:   w_new = w_rd | bus.csr_wdata;
            2'b11:   w_new = w_rd & ~bus.csr_wdata;
            default: w_new = w_rd;
        endcase
    end

    // RS/RC with a zero operand is a pure read and never counts as a write.
    assign w_wr_try = (bus.csr_op == 2'b01) || (bus.csr_op[1] && (bus.csr_wdata != '0));
    assign w_ro     = (bus.csr_addr[11:10] == 2'b11);
    assign w_event  = bus.trap_valid || bus.mret;
    assign w_wen    = bus.csr_valid && w_wr_try && w_impl && !w_ro && !w_event;

    assign bus.csr_rdata   = w_impl ? w_rd : '0;
    assign bus.csr_illegal = !w_impl || (w_wr_try && w_ro);

    // ------------------------------------------------------------------
    // Architectural state: trap > mret > CSR write
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mie      <= MSTATUS_RST[3];
            r_mpie     <= MSTATUS_RST[7];
            r_mtvec    <= '0;
            r_mscratch <= '0;
            r_mepc     <= '0;
            r_mcause   <= '0;
        end else if (bus.trap_valid) begin
            r_mepc   <= {bus.trap_pc[XLEN-1:2], 2'b00};
            r_mcause <= bus.trap_cause;
            r_mpie   <= r_mie;
            r_mie    <= 1'b0;
        end else if (bus.mret) begin
            r_mie  <= r_mpie;
            r_mpie <= 1'b1;
        end else if (w_wen) begin
            case (bus.csr_addr)
                c_A_MSTATUS: begin
                    r_mie  <= w_new[3];
                    r_mpie <= w_new[7];
                end
                c_A_MTVEC:    r_mtvec    <= {w_new[XLEN-1:2], 2'b00};
                c_A_MSCRATCH: r_mscratch <= w_new;
                c_A_MEPC:     r_mepc     <= {w_new[XLEN-1:2], 2'b00};
                c_A_MCAUSE:   r_mcause   <= w_new;
                default: ;
            endcase
        end
    end

`ifdef CSR_COUNTERS_EN
    always_comb begin
        w_wr64             = '0;
        w_wr64[XLEN-1:0]   = w_new;
    end

    // Counters free-run; a same-cycle CSR write overrides the increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcycle   <= '0;
            r_minstret <= '0;
        end else begin
            r_mcycle <= r_mcycle + 64'd1;
            if (bus.instret) r_minstret <= r_minstret + 64'd1;
            if (w_wen) begin
                case (bus.csr_addr)
                    12'hB00: begin
                        if (XLEN == 32) r_mcycle <= {r_mcycle[63:32], w_wr64[31:0]};
                        else            r_mcycle <= w_wr64;
                    end
                    12'hB02: begin
                        if (XLEN == 32) r_minstret <= {r_minstret[63:32], w_wr64[31:0]};
                        else            r_minstret <= w_wr64;
                    end
                    12'hB80: r_mcycle   <= {w_wr64[31:0], r_mcycle[31:0]};
                    12'hB82: r_minstret <= {w_wr64[31:0], r_minstret[31:0]};
                    default: ;
                endcase
            end
        end
    end

    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, bus.trap_pc[1:0], w_cyc_hi, w_ret_hi};
`else
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, bus.trap_pc[1:0], bus.instret};
`endif

    // ------------------------------------------------------------------
    // Redirect FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= c_ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Both states leave on the same condition: any new event (re)enters REDIR.
    always_comb begin
        w_state_nxt = c_ST_IDLE;
        case (r_state)
            c_ST_IDLE:  if (w_event) w_state_nxt = c_ST_REDIR;
            c_ST_REDIR: if (w_event) w_state_nxt = c_ST_REDIR;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Reset squashes a pulse that is already in flight this cycle.
    always_comb begin
        bus.redirect_valid = (r_state == c_ST_REDIR) && !rst;
    end

    // Target sampled before any same-cycle CSR update takes effect.
    always_ff @(posedge clk) begin
        if (rst)                 r_redirect_pc <= '0;
        else if (bus.trap_valid) r_redirect_pc <= r_mtvec;
        else if (bus.mret)       r_redirect_pc <= r_mepc;
    end

    assign bus.redirect_pc = r_redirect_pc;

endmodule
`default_nettype wire

// File: tb/tb_csr_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_csr_unit
// Description : Self-checking bench for csr_unit (XLEN=64): directed vector
//               table, hand-written trap/mret/reset sequences, and random
//               traffic against a behavioural CSR model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_unit;
    localparam int          XLEN    = 64;
    localparam logic [63:0] RST_MST = 64'h0000_000a_0000_1800;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    csr_unit_if #(.XLEN(XLEN)) bus ();

    csr_unit #(.XLEN(XLEN), .MSTATUS_RST(RST_MST)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- behavioural model ----------------
    logic [63:0] m_csr [logic [11:0]];
    bit          m_redir;
    logic [63:0] m_rpc;

    function automatic bit m_impl(input logic [11:0] a);
        case (a)
            12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'hF14: return 1'b1;
`ifdef CSR_COUNTERS_EN
            12'hB00, 12'hB02, 12'hC00, 12'hC02: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [63:0] m_read(input logic [11:0] a);
        if (!m_impl(a)) return 64'h0;
        case (a)
            12'hF14: return 64'h0;
            12'hC00: return m_csr[12'hB00];
            12'hC02: return m_csr[12'hB02];
            default: return m_csr[a];
        endcase
    endfunction

    function automatic logic [63:0] m_legal(input logic [11:0] a, input logic [63:0] v);
        case (a)
            12'h300:          return (v & 64'h88) | (RST_MST & ~64'h88) | 64'h1800;
            12'h305, 12'h341: return v & ~64'h3;
            default:          return v;
        endcase
    endfunction

    task automatic m_reset();
        m_csr[12'h300] = m_legal(12'h300, RST_MST);
        m_csr[12'h305] = 0;
        m_csr[12'h340] = 0;
        m_csr[12'h341] = 0;
        m_csr[12'h342] = 0;
        m_csr[12'hB00] = 0;
        m_csr[12'hB02] = 0;
        m_redir = 1'b0;
        m_rpc   = 0;
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One clock cycle: drive at negedge, compare combinational outputs 1ns later,
    // advance the model on the rising edge, return at the next negedge.
    task automatic cyc(input bit r, input bit v, input logic [1:0] op, input logic [11:0] a,
                       input logic [63:0] wd, input bit tr, input logic [63:0] cause,
                       input logic [63:0] pc, input bit mr, input bit ir, input bit chk,
                       input bit use_exp, input logic [63:0] er, input bit ei, input string nm);
        logic [63:0] old, nv, st;
        bit          try_wr, ill, wen;
        rst = r;
        bus.csr_valid = v;  bus.csr_op = op;  bus.csr_addr = a;  bus.csr_wdata = wd;
        bus.trap_valid = tr; bus.trap_cause = cause; bus.trap_pc = pc;
        bus.mret = mr; bus.instret = ir;
        #1;
        try_wr = (op == 2'b01) || (op[1] && wd != 0);
        ill    = !m_impl(a) || (try_wr && a[11:10] == 2'b11);
        old    = m_read(a);
        if (chk) begin
            if (use_exp) begin
                check({nm, "_rdata"}, bus.csr_rdata, er);
                check({nm, "_illegal"}, {63'h0, bus.csr_illegal}, {63'h0, ei});
            end else begin
                check({nm, "_rdata"}, bus.csr_rdata, old);
                check({nm, "_illegal"}, {63'h0, bus.csr_illegal}, {63'h0, ill});
            end
            check({nm, "_redir_v"}, {63'h0, bus.redirect_valid}, {63'h0, (m_redir && !r)});
            check({nm, "_redir_pc"}, bus.redirect_pc, m_rpc);
        end
        @(posedge clk);
        if (r) begin
            m_reset();
        end else begin
            wen = v && try_wr && m_impl(a) && (a[11:10] != 2'b11) && !tr && !mr;
            nv  = (op == 2'b01) ? wd : (op == 2'b10) ? (old | wd) : (old & ~wd);
            m_csr[12'hB00] = m_csr[12'hB00] + 1;
            if (ir) m_csr[12'hB02] = m_csr[12'hB02] + 1;
            st = m_csr[12'h300];
            if (tr) begin
                m_redir = 1'b1;
                m_rpc   = m_csr[12'h305];
                m_csr[12'h341] = pc & ~64'h3;
                m_csr[12'h342] = cause;
                st[7] = st[3];
                st[3] = 1'b0;
                m_csr[12'h300] = st;
            end else if (mr) begin
                m_redir = 1'b1;
                m_rpc   = m_csr[12'h341];
                st[3] = st[7];
                st[7] = 1'b1;
                m_csr[12'h300] = st;
            end else begin
                m_redir = 1'b0;
                if (wen) m_csr[a] = m_legal(a, nv);
            end
        end
        @(negedge clk);
    endtask

    task automatic rd(input logic [11:0] a, input logic [63:0] e, input string nm);
        cyc(0, 1, 2'b00, a, 0, 0, 0, 0, 0, 0, 1, 1, e, 0, nm);
    endtask

    task automatic op_m(input logic [1:0] op, input logic [11:0] a, input logic [63:0] wd,
                        input bit ir, input string nm);
        cyc(0, 1, op, a, wd, 0, 0, 0, 0, ir, 1, 0, 0, 0, nm);
    endtask

    task automatic trap(input logic [63:0] pc, input logic [63:0] cause, input string nm);
        cyc(0, 0, 2'b00, 12'h300, 0, 1, cause, pc, 0, 0, 1, 0, 0, 0, nm);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [1:0]  op;
        logic [11:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        bit          ill;
    } vec_t;

    vec_t        tbl [$];
    logic [11:0] alist [12];
    logic [63:0] rwd;
    bit          rr, rtr, rmr;

    initial begin
        tbl.push_back('{2'b00, 12'h300, 64'h0, 64'h0000_000a_0000_1800, 1'b0});
        tbl.push_back('{2'b00, 12'h305, 64'h0, 64'h0, 1'b0});
        tbl.push_back('{2'b00, 12'h341, 64'h0, 64'h0, 1'b0});
        tbl.push_back('{2'b00, 12'h342, 64'h0, 64'h0, 1'b0});
        tbl.push_back('{2'b01, 12'h305, 64'h8000_0103, 64'h0, 1'b0});
        tbl.push_back('{2'b00, 12'h305, 64'h0, 64'h8000_0100, 1'b0});
        tbl.push_back('{2'b10, 12'h340, 64'hF0, 64'h0, 1'b0});
        tbl.push_back('{2'b11, 12'h340, 64'h30, 64'hF0, 1'b0});
        tbl.push_back('{2'b10, 12'h340, 64'h0, 64'hC0, 1'b0});
        tbl.push_back('{2'b00, 12'h340, 64'h0, 64'hC0, 1'b0});
        tbl.push_back('{2'b01, 12'hF14, 64'h5, 64'h0, 1'b1});
        tbl.push_back('{2'b00, 12'h7C0, 64'h0, 64'h0, 1'b1});
        tbl.push_back('{2'b10, 12'hF14, 64'h0, 64'h0, 1'b0});
        tbl.push_back('{2'b01, 12'h341, 64'h8000_0007, 64'h0, 1'b0});
        tbl.push_back('{2'b00, 12'h341, 64'h0, 64'h8000_0004, 1'b0});
        tbl.push_back('{2'b01, 12'h300, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_000a_0000_1800, 1'b0});
        tbl.push_back('{2'b00, 12'h300, 64'h0, 64'h0000_000a_0000_1888, 1'b0});
        tbl.push_back('{2'b11, 12'h300, 64'h80, 64'h0000_000a_0000_1888, 1'b0});
        tbl.push_back('{2'b00, 12'h300, 64'h0, 64'h0000_000a_0000_1808, 1'b0});
`ifndef CSR_COUNTERS_EN
        tbl.push_back('{2'b00, 12'hB00, 64'h0, 64'h0, 1'b1});
        tbl.push_back('{2'b01, 12'hC00, 64'h1, 64'h0, 1'b1});
`endif
        alist = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'hF14,
                  12'h7C0, 12'hB00, 12'hB02, 12'hC00, 12'hC02, 12'hB80};

        m_reset();
        cyc(1, 0, 2'b00, 12'h300, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rst0");
        rd(12'h300, 64'h0000_000a_0000_1800, "reset_mstatus");

        foreach (tbl[i])
            cyc(0, 1, tbl[i].op, tbl[i].addr, tbl[i].wdata, 0, 0, 0, 0, 0, 1, 1,
                tbl[i].rdata, tbl[i].ill, $sformatf("vec%0d", i));

        // Trap entry with MIE=1, then mret.
        trap(64'h8000_0006, 64'd11, "trap1");
        check("trap1_pulse", {63'h0, bus.redirect_valid}, 64'h1);
        check("trap1_target", bus.redirect_pc, 64'h8000_0100);
        rd(12'h341, 64'h8000_0004, "trap1_mepc");
        check("trap1_pulse_end", {63'h0, bus.redirect_valid}, 64'h0);
        rd(12'h342, 64'd11, "trap1_mcause");
        rd(12'h300, 64'h0000_000a_0000_1880, "trap1_mstatus");
        cyc(0, 0, 2'b00, 12'h300, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, "mret1");
        check("mret1_pulse", {63'h0, bus.redirect_valid}, 64'h1);
        check("mret1_target", bus.redirect_pc, 64'h8000_0004);
        rd(12'h300, 64'h0000_000a_0000_1888, "mret1_mstatus");

        // Trap wins over a same-cycle mepc write.
        cyc(0, 1, 2'b01, 12'h341, 64'h1234, 1, 64'd2, 64'h200, 0, 0, 1, 0, 0, 0, "trap_vs_wr");
        rd(12'h341, 64'h200, "trap_vs_wr_mepc");

        // Back-to-back traps give back-to-back pulses.
        trap(64'h300, 64'd3, "b2b_a");
        check("b2b_a_pulse", {63'h0, bus.redirect_valid}, 64'h1);
        trap(64'h400, 64'd4, "b2b_b");
        check("b2b_b_pulse", {63'h0, bus.redirect_valid}, 64'h1);
        rd(12'h342, 64'd4, "b2b_mcause");

        // Reset in the cycle after a trap squashes the pulse.
        op_m(2'b01, 12'h340, 64'h55, 0, "pre_rst_wr");
        trap(64'h500, 64'd7, "rst_trap");
        cyc(1, 0, 2'b00, 12'h300, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, "rst_mid");
        check("rst_mid_pulse", {63'h0, bus.redirect_valid}, 64'h0);
        rd(12'h300, 64'h0000_000a_0000_1800, "rst_mstatus");
        rd(12'h341, 64'h0, "rst_mepc");
        rd(12'h342, 64'h0, "rst_mcause");
        rd(12'h340, 64'h0, "rst_mscratch");
        rd(12'h305, 64'h0, "rst_mtvec");

`ifdef CSR_COUNTERS_EN
        op_m(2'b01, 12'hB00, 64'hFFFF_FFFF_FFFF_FFFF, 0, "mcycle_wr");
        rd(12'hB00, 64'hFFFF_FFFF_FFFF_FFFF, "mcycle_ones");
        rd(12'hB00, 64'h0, "mcycle_wrap");
        rd(12'hB00, 64'h1, "mcycle_inc");
        op_m(2'b01, 12'hB02, 64'h0, 0, "minstret_clr");
        for (int i = 0; i < 5; i++) op_m(2'b00, 12'h300, 0, 1, "instret_run");
        rd(12'hB02, 64'd5, "minstret_5");
        cyc(0, 1, 2'b01, 12'hC00, 64'h1, 0, 0, 0, 0, 0, 1, 0, 0, 0, "cycle_ro_wr");
`endif

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rr  = ($urandom_range(0, 99) == 0);
            rtr = ($urandom_range(0, 99) < 8);
            rmr = ($urandom_range(0, 99) < 8);
            case ($urandom_range(0, 3))
                0:       rwd = 64'h0;
                1:       rwd = 64'($urandom_range(0, 255));
                default: rwd = {$urandom, $urandom};
            endcase
            cyc(rr, $urandom_range(0, 99) < 80, 2'($urandom_range(0, 3)),
                alist[$urandom_range(0, 11)], rwd, rtr, {$urandom, $urandom},
                {$urandom, $urandom}, rmr, $urandom_range(0, 1) == 1, 1, 0, 0, 0, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/csr_unit.md
# csr_unit

Parametrised machine-mode CSR unit for the NPC core, replacing the fixed four-register CSR array. It executes Zicsr read-modify-write operations, sequences trap entry and `mret` (mstatus stacking plus a registered PC redirect), and maintains free-running cycle and retire counters. It sits beside the register file in the execute stage; the PC unit consumes its redirect.

## Interface
Parameters:
- `XLEN`, 64: datapath width; 32 or 64 only.
- `MSTATUS_RST`, 64'h0000_000a_0000_1800: mstatus reset value, truncated to XLEN.

Ports:
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  reset; synchronous and active-high.
- `csr_valid`  input  1  a CSR instruction executes this cycle.
- `csr_op`  input  2  operation: 01 RW, 10 RS, 11 RC, 00 read-only/no-op.
- `csr_addr`  input  12  CSR address.
- `csr_wdata`  input  XLEN  rs1 value or zero-extended zimm.
- `csr_rdata`  output  XLEN  old CSR value, combinational.
- `csr_illegal`  output  1  combinational; address unimplemented, or write attempted to a read-only CSR.
- `trap_valid`  input  1  trap entry this cycle (ecall etc.).
- `trap_cause`  input  XLEN  mcause value for the trap.
- `trap_pc`  input  XLEN  PC of the trapping instruction.
- `mret`  input  1  mret executes this cycle.
- `instret`  input  1  one instruction retires this cycle.
- `redirect_valid`  output  1  one-cycle pulse; the PC must load `redirect_pc`.
- `redirect_pc`  output  XLEN  redirect target.

## Operation
- Implemented CSRs:
  - mstatus 0x300.
  - mtvec 0x305.
  - mscratch 0x340.
  - mepc 0x341.
  - mcause 0x342.
  - mhartid 0xF14: read-only, reads 0.
  - Counters gated by the macro (see Configuration).
- Unimplemented address: `csr_rdata` is 0, `csr_illegal` is 1, no state change.
- Write value:
  - RW: new = wdata.
  - RS: new = old | wdata.
  - RC: new = old & ~wdata.
  - RS/RC with `csr_wdata` == 0 performs no write (no side effects).
  - op 00 never writes.
- Any write to addr[11:10] == 2'b11 sets `csr_illegal` and is discarded. RS/RC with zero wdata to a read-only CSR is legal.
- mstatus is WARL:
  - Only MIE[3] and MPIE[7] are writable.
  - MPP[12:11] always reads 2'b11.
  - All other bits hold `MSTATUS_RST`.
- mtvec: bits [1:0] are forced to 0 (direct mode only). mepc: bits [1:0] are forced to 0 on every write.
- Trap entry (`trap_valid`):
  - mepc <= trap_pc & ~3.
  - mcause <= trap_cause.
  - MPIE <= MIE, then MIE <= 0.
- mret: MIE <= MPIE, MPIE <= 1.
- Same-cycle priority: trap > mret > CSR write. The lower-priority register effects are dropped; `csr_rdata` still reports the old value.
- Redirect state machine, two states:
  - IDLE → REDIR on trap or mret.
  - REDIR → IDLE next cycle, unless a new trap or mret arrives, in which case it stays REDIR with a new target.
  - `redirect_valid` is 1 only in REDIR.
  - Target is latched at entry: mtvec for a trap (value before any same-cycle write), mepc for mret.
- mcycle increments every cycle. minstret increments when `instret` is 1.
  - Both wrap from all-ones to 0.
  - A CSR write to a counter in the same cycle wins over the increment.

## Timing
- `csr_rdata` and `csr_illegal` are combinational from `csr_addr`, `csr_op`, `csr_wdata`.
- CSR writes, trap, and mret effects are visible on the next rising edge (read-after-write needs 1 cycle).
- `redirect_valid` asserts exactly 1 cycle after `trap_valid`/`mret`, for 1 cycle per event.
- Back-to-back traps give back-to-back pulses.
- Reset values:
  - mstatus = `MSTATUS_RST` with MPP forced to 11.
  - mtvec, mepc, mcause, mscratch, mcycle, minstret = 0.
  - `redirect_valid` = 0, `redirect_pc` = 0; state = IDLE.
- `rst` asserted mid-operation: reset takes priority over trap, mret and writes in that cycle. A pending redirect pulse is squashed.

## Configuration
- `CSR_COUNTERS_EN` defined:
  - mcycle 0xB00 and minstret 0xB02 are implemented and writable.
  - User aliases cycle 0xC00 and instret 0xC02 are read-only.
  - With XLEN=32, mcycleh 0xB80 / minstreth 0xB82 (upper halves, 64-bit counters) are also implemented.
- `CSR_COUNTERS_EN` not defined: no counter registers; all of the above addresses are unimplemented (rdata 0, illegal 1).

## Test plan
- Reset → read 0x300 returns 0x0000000a00001800. Read 0x305, 0x341, 0x342 → 0; `redirect_valid` = 0.
- RW mtvec 0x80000103 → read gives 0x80000100. RS mscratch 0xF0, then RC 0x30 → mscratch = 0xC0. RS with wdata 0 → no change, not illegal.
- MIE=1, trap (pc 0x80000006, cause 11):
  - Next cycle: mepc = 0x80000004, mcause = 11, MIE = 0, MPIE = 1.
  - `redirect_valid` = 1 with `redirect_pc` = mtvec.
  - Then mret → MIE = 1, redirect to 0x80000004.
- Same-cycle trap plus RW mepc 0x1234 → mepc = trap value, write dropped. Write to 0xF14 or read of 0x7C0 → `csr_illegal` = 1, state unchanged.
- With `CSR_COUNTERS_EN`:
  - Write mcycle = all-ones → wraps to 0, then +1 per cycle.
  - `instret` held 5 cycles → minstret += 5.
  - Write 0xC00 → illegal.
  - Without the macro, read 0xB00 → 0 with illegal = 1.
- Assert `rst` in the cycle after a trap → `redirect_valid` stays 0 and all CSRs return to reset values.
